// File: rtl/result_display_driver_if.sv
// Bundles the value/load request and the conversion/display outputs of result_display_driver.
// The master drives the request side; the display driver is the slave.
interface result_display_driver_if;
    logic [7:0]  value;
    logic        load;
    logic        busy;
    logic        done;
    logic [11:0] digits;
    logic [6:0]  seg;
    logic [2:0]  an;

    modport master (output value, load, input busy, done, digits, seg, an);
    modport slave  (input value, load, output busy, done, digits, seg, an);
endinterface

// File: rtl/result_display_driver.sv
// Converts an 8-bit result to BCD with a sequential double-dabble engine and scans it
// onto a 3-digit active-low 7-segment display with leading-zero blanking.
module result_display_driver #(
    parameter int unsigned REFRESH_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    result_display_driver_if.slave bus
);
    localparam int unsigned CW = $clog2(REFRESH_CYCLES);
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state, state_next;
    logic [7:0]     shift_reg;
    logic [11:0]    scratch;
    logic [2:0]     iter;
    logic [11:0]    digits;
    logic [11:0]    corrected;
    logic [19:0]    shifted;
    logic [CW-1:0]  refresh_cnt;
    logic [1:0]     scan_idx;
    logic [3:0]     slot_digit;
    logic [2:0]     slot_an;
    logic           slot_blank;
    logic [6:0]     seg_q;
    logic [2:0]     an_q;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign corrected = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
    assign shifted   = {corrected, shift_reg} << 1;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load) state_next = SHIFT;
            end
            SHIFT: begin
                bus.busy = 1'b1;
                if (iter == 3'd7) state_next = DONE;
            end
            DONE: begin
                bus.busy   = 1'b1;
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The final shift result is published the same edge the FSM moves into DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            scratch   <= '0;
            iter      <= '0;
            digits    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        shift_reg <= bus.value;
                        scratch   <= '0;
                        iter      <= '0;
                    end
                end
                SHIFT: begin
                    scratch   <= shifted[19:8];
                    shift_reg <= shifted[7:0];
                    iter      <= iter + 3'd1;
                    if (iter == 3'd7) digits <= shifted[19:8];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            scan_idx    <= 2'd0;
        end else if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
            scan_idx    <= (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Slot 0 is ones, 1 is tens, 2 is hundreds; the ones digit is never blanked.
    always_comb begin
        slot_digit = digits[3:0];
        slot_an    = 3'b110;
        slot_blank = 1'b0;
        case (scan_idx)
            2'd1: begin
                slot_digit = digits[7:4];
                slot_an    = 3'b101;
                slot_blank = (digits[11:8] == 4'd0) && (digits[7:4] == 4'd0);
            end
            2'd2: begin
                slot_digit = digits[11:8];
                slot_an    = 3'b011;
                slot_blank = (digits[11:8] == 4'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an_q  <= 3'b110;
            seg_q <= 7'b1000000;
        end else if (slot_blank) begin
            an_q  <= 3'b111;
            seg_q <= 7'b1111111;
        end else begin
            an_q  <= slot_an;
            seg_q <= decode(slot_digit);
        end
    end

    assign bus.digits = digits;
    assign bus.an     = an_q;
    assign bus.seg    = seg_q;
endmodule

// File: tb/tb_result_display_driver.sv
// Directed bench for result_display_driver: conversion latency, BCD results, scan with
// blanking, loads dropped while busy, and reset during a conversion.
module tb_result_display_driver;
    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    result_display_driver_if bus ();

    result_display_driver #(.REFRESH_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected {an,seg} for a scan slot (0 ones, 1 tens, 2 hundreds) showing digits d.
    function automatic logic [9:0] slot_expect(input logic [11:0] d, input int slot);
        if (slot == 0) return {3'b110, seg_of(d[3:0])};
        if (slot == 1) begin
            if (d[11:8] == 4'd0 && d[7:4] == 4'd0) return {3'b111, 7'b1111111};
            return {3'b101, seg_of(d[7:4])};
        end
        if (d[11:8] == 4'd0) return {3'b111, 7'b1111111};
        return {3'b011, seg_of(d[11:8])};
    endfunction

    task automatic pulse_load(input logic [7:0] v);
        @(negedge clk);
        bus.value = v;
        bus.load  = 1'b1;
        @(posedge clk);
        #1 bus.load = 1'b0;
    endtask

    // Collects 24 samples and accepts only if some scan phase explains every one of them.
    task automatic check_scan(input logic [11:0] d, input string name);
        logic [2:0] an_s [24];
        logic [6:0] seg_s [24];
        bit found = 0;
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            an_s[j]  = bus.an;
            seg_s[j] = bus.seg;
        end
        for (int p = 0; p < 12; p++) begin
            bit ok = 1;
            for (int j = 0; j < 24; j++)
                if ({an_s[j], seg_s[j]} !== slot_expect(d, ((j + p) / 4) % 3)) ok = 0;
            if (ok) found = 1;
        end
        total++;
        if (found) passed++;
        else $display("[TB] FAIL %s: first sample an=%b seg=%b, required a 4-cycle scan of digits %h (ones an=110 seg=%b)",
                      name, an_s[0], seg_s[0], d, seg_of(d[3:0]));
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.load  = 1'b0;
        bus.value = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (bus.busy === 1'b0) passed++; else $display("[TB] FAIL reset_busy: got %b want 0", bus.busy);
        total++; if (bus.done === 1'b0) passed++; else $display("[TB] FAIL reset_done: got %b want 0", bus.done);
        total++; if (bus.digits === 12'h000) passed++; else $display("[TB] FAIL reset_digits: got %h want 000", bus.digits);
        total++; if (bus.an === 3'b110) passed++; else $display("[TB] FAIL reset_an: got %b want 110", bus.an);
        total++; if (bus.seg === 7'b1000000) passed++; else $display("[TB] FAIL reset_seg: got %b want 1000000", bus.seg);
        reset = 1'b0;
    endtask

    task automatic test_latency_255();
        pulse_load(8'd255);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            total++;
            if (bus.busy === 1'b1) passed++;
            else $display("[TB] FAIL busy_k+%0d: got %b want 1", c, bus.busy);
            total++;
            if (bus.done === (c == 9)) passed++;
            else $display("[TB] FAIL done_k+%0d: got %b want %0d", c, bus.done, (c == 9));
            if (c == 9) begin
                total++;
                if (bus.digits === 12'h255) passed++;
                else $display("[TB] FAIL digits_255: got %h want 255", bus.digits);
            end
        end
        @(negedge clk);
        total++; if (bus.busy === 1'b0) passed++; else $display("[TB] FAIL busy_k+10: got %b want 0", bus.busy);
        total++; if (bus.done === 1'b0) passed++; else $display("[TB] FAIL done_k+10: got %b want 0", bus.done);
        check_scan(12'h255, "scan_255");
    endtask

    task automatic test_convert(input logic [7:0] v, input logic [11:0] expd, input string name);
        bit got = 0;
        pulse_load(v);
        for (int c = 0; c < 12 && !got; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) got = 1;
        end
        total++;
        if (got) passed++;
        else $display("[TB] FAIL %s_done: got no done pulse within 12 cycles, want one", name);
        total++;
        if (bus.digits === expd) passed++;
        else $display("[TB] FAIL %s_digits: got %h want %h", name, bus.digits, expd);
        check_scan(expd, {name, "_scan"});
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        pulse_load(8'd42);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
            if (c == 10 || c == 11) begin
                total++;
                if (bus.busy === 1'b0) passed++;
                else $display("[TB] FAIL drop_busy_k+%0d: got %b want 0", c, bus.busy);
            end
            bus.load  = (c == 3 || c == 9);
            bus.value = bus.load ? 8'd99 : 8'd42;
        end
        bus.load = 1'b0;
        total++; if (dones == 1) passed++; else $display("[TB] FAIL drop_done_count: got %0d want 1", dones);
        total++; if (bus.digits === 12'h042) passed++; else $display("[TB] FAIL drop_digits: got %h want 042", bus.digits);
    endtask

    task automatic test_reset_mid_conversion();
        int dones = 0;
        pulse_load(8'd200);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
            if (c == 5) reset = 1'b1;
        end
        @(negedge clk);
        total++; if (bus.busy === 1'b0) passed++; else $display("[TB] FAIL midrst_busy: got %b want 0", bus.busy);
        total++; if (bus.digits === 12'h000) passed++; else $display("[TB] FAIL midrst_digits: got %h want 000", bus.digits);
        total++; if (bus.done === 1'b0) passed++; else $display("[TB] FAIL midrst_done: got %b want 0", bus.done);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        total++; if (dones == 0) passed++; else $display("[TB] FAIL midrst_no_done: got %0d pulses want 0", dones);
        test_convert(8'd0, 12'h000, "zero");
    endtask

    initial begin
        test_reset();
        test_latency_255();
        test_convert(8'd7, 12'h007, "seven");
        test_convert(8'd100, 12'h100, "hundred");
        test_back_to_back();
        test_reset_mid_conversion();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
